// File: rtl/fifo_arb_pkg.sv
`timescale 1ns/1ps
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   fifo_arb_state_t    : arbiter FSM states
//   FIFO_ARB_CNT_BITS   : width of the optional statistics counters
//   FIFO_ARB_N_REQ_MIN/MAX : supported requester count range
//   BYTE_BITS           : default data width (matches the FIFO COLS)
//   sat_inc()           : saturating increment for the statistics counters
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } fifo_arb_state_t;

  localparam int FIFO_ARB_CNT_BITS  = 16;
  localparam int FIFO_ARB_N_REQ_MIN = 2;
  localparam int FIFO_ARB_N_REQ_MAX = 8;
  localparam int BYTE_BITS          = 8;

  function automatic logic [FIFO_ARB_CNT_BITS-1:0] sat_inc(
    input logic [FIFO_ARB_CNT_BITS-1:0] v
  );
    return (&v) ? v : v + FIFO_ARB_CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
`timescale 1ns/1ps
// rr_picker
// Combinational round-robin picker: returns the first valid index after
// last_grant, scanning cyclically.
// Ports:
//   valid      in  [N]  : request vector
//   last_grant in  [IW] : index granted most recently
//   any        out      : at least one request is valid
//   winner     out [IW] : chosen index (0 when nothing is valid)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last_grant,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    any    = |valid;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!found && valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
`timescale 1ns/1ps
// fifo_write_arbiter
// Round-robin arbiter sharing the single FIFO write port among N_REQ
// producers. Owns the wr_trigger / wr_rdy / wr_done handshake, holds off
// while the FIFO is full and aborts a hung write after TIMEOUT_CYCLES.
// Ports:
//   clk, reset, clk_en          : clock, async active-high reset, enable
//   req_valid/req_data/req_ack  : producer side (data packed, slice i = req i)
//   fifo_wr_trigger/fifo_wr_data: to FIFO write port
//   fifo_wr_rdy/fifo_wr_done/fifo_is_full : from FIFO
//   err_timeout                 : one-cycle pulse, current write aborted
//   busy                        : FSM not in IDLE
// Optional build macro FIFO_ARB_STATS_EN adds grant_count (per requester)
// and timeout_count saturating counters.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | no write in flight; arbitrate when FIFO ready, not full
// ISSUE     | trigger high, waiting for FIFO to drop wr_rdy
// WAIT_DONE | trigger low, waiting for wr_done or wr_rdy rising
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int COLS           = BYTE_BITS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*COLS-1:0] req_data,
  output logic [N_REQ-1:0]      req_ack,
  output logic                  fifo_wr_trigger,
  output logic [COLS-1:0]       fifo_wr_data,
  input  logic                  fifo_wr_rdy,
  input  logic                  fifo_wr_done,
  input  logic                  fifo_is_full,
  output logic                  err_timeout,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*FIFO_ARB_CNT_BITS-1:0] grant_count,
  output logic [FIFO_ARB_CNT_BITS-1:0]       timeout_count
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  // Down-counter terminal count at zero lands the abort on the edge where
  // the elapsed enabled-cycle count since the grant reaches TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 2);

  fifo_arb_state_t   state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rdy_q;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [COLS-1:0]   pick_data;
  logic              wr_finish;
  logic              tmo_hit;

  rr_picker #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_data = req_data[i*COLS +: COLS];
    end
  end

  // rdy_q only advances on enabled edges, so a wr_rdy rise that happens
  // while clk_en is low is still seen as a rise on the next enabled edge.
  assign wr_finish = (state == WAIT_DONE) &&
                     (fifo_wr_done || (fifo_wr_rdy && !rdy_q));
  // A completion seen on the same edge as the terminal count wins.
  assign tmo_hit   = (state != IDLE) && !wr_finish && (tmo_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= '0;
      last_grant      <= IDX_W'(N_REQ - 1);
      tmo_cnt         <= '0;
      rdy_q           <= 1'b0;
      req_ack         <= '0;
      fifo_wr_trigger <= 1'b0;
      fifo_wr_data    <= '0;
      err_timeout     <= 1'b0;
      busy            <= 1'b0;
    end else if (clk_en) begin
      req_ack     <= '0;
      err_timeout <= 1'b0;
      rdy_q       <= fifo_wr_rdy;
      case (state)
        IDLE: begin
          if (pick_any && !fifo_is_full && fifo_wr_rdy) begin
            grant           <= pick_idx;
            fifo_wr_data    <= pick_data;
            fifo_wr_trigger <= 1'b1;
            tmo_cnt         <= TMO_LOAD;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          if (wr_finish) begin
            req_ack    <= N_REQ'(1) << grant;
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (tmo_hit) begin
            err_timeout     <= 1'b1;
            fifo_wr_trigger <= 1'b0;
            last_grant      <= grant;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
            if (state == ISSUE && !fifo_wr_rdy) begin
              fifo_wr_trigger <= 1'b0;
              state           <= WAIT_DONE;
            end
          end
        end
        default: begin
          fifo_wr_trigger <= 1'b0;
          busy            <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_count   <= '0;
      timeout_count <= '0;
    end else if (clk_en) begin
      if (wr_finish) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant == IDX_W'(i)) begin
            grant_count[i*FIFO_ARB_CNT_BITS +: FIFO_ARB_CNT_BITS] <=
              sat_inc(grant_count[i*FIFO_ARB_CNT_BITS +: FIFO_ARB_CNT_BITS]);
          end
        end
      end
      if (tmo_hit) timeout_count <= sat_inc(timeout_count);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for fifo_write_arbiter with a behavioural FIFO
// write-port responder and a round-robin reference model.
module tb_fifo_write_arbiter;

  localparam int N_REQ = 4;
  localparam int COLS  = 8;
  localparam int TMO   = 64;

  logic                  clk    = 1'b0;
  logic                  reset  = 1'b1;
  logic                  clk_en = 1'b1;
  logic [N_REQ-1:0]      req_valid = '0;
  logic [COLS-1:0]       word [N_REQ];
  logic [N_REQ*COLS-1:0] req_data;
  logic [N_REQ-1:0]      req_ack;
  logic                  fifo_wr_trigger;
  logic [COLS-1:0]       fifo_wr_data;
  logic                  fifo_wr_rdy;
  logic                  fifo_wr_done;
  logic                  fifo_is_full = 1'b0;
  logic                  err_timeout;
  logic                  busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N_REQ*16-1:0]   grant_count;
  logic [15:0]           timeout_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ref_last    = N_REQ - 1;

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign req_data[g*COLS +: COLS] = word[g];
  end

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N_REQ          (N_REQ),
    .COLS           (COLS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .fifo_wr_trigger (fifo_wr_trigger),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_wr_rdy     (fifo_wr_rdy),
    .fifo_wr_done    (fifo_wr_done),
    .fifo_is_full    (fifo_is_full),
    .err_timeout     (err_timeout),
    .busy            (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_count     (grant_count),
    .timeout_count   (timeout_count)
`endif
  );

  // FIFO write-port responder: accepts a trigger while ready, drops ready
  // for wr_lat cycles, then raises ready with a done pulse. In hang mode
  // ready never comes back and nothing is stored.
  logic [COLS-1:0] fifo_q [$];
  logic hang   = 1'b0;
  int   wr_lat = 1;
  int   lat_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_rdy  <= 1'b1;
      fifo_wr_done <= 1'b0;
      lat_cnt      <= 0;
    end else begin
      fifo_wr_done <= 1'b0;
      if (fifo_wr_rdy && fifo_wr_trigger) begin
        fifo_wr_rdy <= 1'b0;
        lat_cnt     <= wr_lat;
        if (!hang && !fifo_is_full) fifo_q.push_back(fifo_wr_data);
      end else if (!fifo_wr_rdy && !hang) begin
        if (lat_cnt <= 1) begin
          fifo_wr_rdy  <= 1'b1;
          fifo_wr_done <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  function automatic int ref_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N_REQ; i++) word[i] = '0;
    fifo_is_full = 1'b0;
    hang = 1'b0;
    wr_lat = 1;
    clk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    fifo_q.delete();
    ref_last = N_REQ - 1;
  endtask

  task automatic wait_ack(input int budget, output logic [N_REQ-1:0] ack,
                          output int cycles);
    ack = '0;
    cycles = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (req_ack !== '0) begin
        ack = req_ack;
        return;
      end
    end
  endtask

  task automatic check_pop(input string name, input logic [COLS-1:0] exp);
    logic [COLS-1:0] got;
    got = 'x;
    if (fifo_q.size() > 0) got = fifo_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: fifo word got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) word[i] = COLS'(8'hA0 + i);
    tick();
    tick();
    vectors++;
    if (req_ack !== '0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", req_ack); end
    vectors++;
    if (fifo_wr_trigger !== 1'b0) begin miscompares++; $display("FAIL reset_trigger: got %b expected 0", fifo_wr_trigger); end
    vectors++;
    if (fifo_wr_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", fifo_wr_data); end
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] ack;
    int cyc;
    apply_reset();
    word[2] = 8'h41;
    req_valid = 4'b0100;
    tick();
    vectors++;
    if (fifo_wr_trigger !== 1'b1) begin miscompares++; $display("FAIL single_trigger_latency: got %b expected 1", fifo_wr_trigger); end
    vectors++;
    if (fifo_wr_data !== 8'h41) begin miscompares++; $display("FAIL single_data: got %h expected 41", fifo_wr_data); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    // withdrawal and data changes after grant must not disturb the write
    req_valid = '0;
    word[2] = 8'hFF;
    wait_ack(20, ack, cyc);
    vectors++;
    if (ack !== 4'b0100) begin miscompares++; $display("FAIL single_ack: got %b expected 0100", ack); end
    tick();
    vectors++;
    if (req_ack !== '0) begin miscompares++; $display("FAIL single_ack_width: got %b expected 0000", req_ack); end
    check_pop("single_fifo", 8'h41);
  endtask

  task automatic test_fairness();
    logic [N_REQ-1:0] ack;
    int cyc, exp;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) word[i] = COLS'(i + 1);
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      exp = ref_pick(req_valid, ref_last);
      wait_ack(20, ack, cyc);
      vectors++;
      if (ack !== onehot(exp)) begin miscompares++; $display("FAIL fair_order[%0d]: got %b expected %b", n, ack, onehot(exp)); end
      vectors++;
      if (cyc != 4) begin miscompares++; $display("FAIL fair_throughput[%0d]: got %0d cycles expected 4", n, cyc); end
      ref_last = exp;
    end
    req_valid = '0;
    check_pop("fair_fifo0", 8'd1);
    check_pop("fair_fifo1", 8'd2);
    check_pop("fair_fifo2", 8'd3);
    check_pop("fair_fifo3", 8'd4);
    check_pop("fair_fifo4", 8'd1);
    repeat (4) tick();
  endtask

  task automatic test_full();
    logic [N_REQ-1:0] ack;
    int cyc;
    apply_reset();
    fifo_is_full = 1'b1;
    word[0] = 8'h5A;
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (fifo_wr_trigger !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL full_holdoff[%0d]: trigger %b busy %b expected 0 0", c, fifo_wr_trigger, busy);
      end
    end
    fifo_is_full = 1'b0;
    tick();
    vectors++;
    if (fifo_wr_trigger !== 1'b1) begin miscompares++; $display("FAIL full_release: trigger got %b expected 1", fifo_wr_trigger); end
    wait_ack(20, ack, cyc);
    vectors++;
    if (ack !== 4'b0001) begin miscompares++; $display("FAIL full_ack: got %b expected 0001", ack); end
    req_valid = '0;
    check_pop("full_fifo", 8'h5A);
  endtask

  task automatic test_timeout();
    logic [N_REQ-1:0] ack;
    int cyc, k, exp;
    logic ack_seen;
    apply_reset();
    hang = 1'b1;
    word[0] = 8'h11;
    word[1] = 8'h22;
    req_valid = 4'b0011;
    exp = ref_pick(req_valid, ref_last);
    tick();
    vectors++;
    if (fifo_wr_trigger !== 1'b1 || fifo_wr_data !== word[exp]) begin
      miscompares++;
      $display("FAIL tmo_grant: trigger %b data %h expected 1 %h", fifo_wr_trigger, fifo_wr_data, word[exp]);
    end
    k = 0;
    ack_seen = 1'b0;
    while (k < 100) begin
      tick();
      k++;
      if (req_ack !== '0) ack_seen = 1'b1;
      if (err_timeout === 1'b1) break;
    end
    vectors++;
    if (err_timeout !== 1'b1 || k != TMO - 1) begin
      miscompares++;
      $display("FAIL tmo_latency: err %b after %0d cycles expected 1 after %0d", err_timeout, k, TMO - 1);
    end
    vectors++;
    if (ack_seen !== 1'b0) begin miscompares++; $display("FAIL tmo_no_ack: ack seen %b expected 0", ack_seen); end
    vectors++;
    if (fifo_wr_trigger !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_abort_state: trigger %b busy %b expected 0 0", fifo_wr_trigger, busy);
    end
    ref_last = exp;
    hang = 1'b0;
    exp = ref_pick(req_valid, ref_last);
    tick();
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse_width: err got %b expected 0", err_timeout); end
    wait_ack(30, ack, cyc);
    vectors++;
    if (ack !== onehot(exp)) begin miscompares++; $display("FAIL tmo_next_grant: got %b expected %b", ack, onehot(exp)); end
    req_valid = '0;
    check_pop("tmo_fifo", 8'h22);
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] ack;
    int cyc, n;
    apply_reset();
    wr_lat = 10;
    word[0] = 8'h33;
    req_valid = 4'b0001;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(busy === 1'b1 && fifo_wr_trigger === 1'b0) && n < 20);
    vectors++;
    if (n >= 20) begin miscompares++; $display("FAIL rstmid_reach_wait: busy %b trigger %b expected 1 0", busy, fifo_wr_trigger); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (fifo_wr_trigger !== 1'b0) begin miscompares++; $display("FAIL rstmid_trigger: got %b expected 0", fifo_wr_trigger); end
    vectors++;
    if (req_ack !== '0) begin miscompares++; $display("FAIL rstmid_ack: got %b expected 0", req_ack); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    word[3] = 8'h44;
    req_valid = 4'b1001;
    wr_lat = 1;
    #2 reset = 1'b0;
    fifo_q.delete();
    ref_last = N_REQ - 1;
    wait_ack(30, ack, cyc);
    vectors++;
    if (ack !== 4'b0001) begin miscompares++; $display("FAIL rstmid_priority: got %b expected 0001", ack); end
    req_valid[0] = 1'b0;
    wait_ack(30, ack, cyc);
    vectors++;
    if (ack !== 4'b1000) begin miscompares++; $display("FAIL rstmid_second: got %b expected 1000", ack); end
    req_valid = '0;
    check_pop("rstmid_fifo0", 8'h33);
    check_pop("rstmid_fifo1", 8'h44);
  endtask

  task automatic test_clk_en();
    int n, en_cnt;
    logic en_prev, found;
    apply_reset();
    wr_lat = 3;
    word[1] = 8'h77;
    req_valid = 4'b0010;
    n = 0;
    found = 1'b0;
    while (n < 80 && !found) begin
      tick();
      n++;
      if (req_ack !== '0) found = 1'b1;
      else clk_en = ~clk_en;
    end
    vectors++;
    if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL clken_ack: got %b expected 0010", req_ack); end
    req_valid = '0;
    clk_en = 1'b0;
    tick();
    vectors++;
    if (req_ack !== 4'b0010) begin miscompares++; $display("FAIL clken_ack_hold: got %b expected 0010", req_ack); end
    clk_en = 1'b1;
    tick();
    vectors++;
    if (req_ack !== '0) begin miscompares++; $display("FAIL clken_ack_one_enabled: got %b expected 0000", req_ack); end
    check_pop("clken_fifo", 8'h77);

    // timeout counts only enabled cycles
    hang = 1'b1;
    word[2] = 8'h99;
    req_valid = 4'b0100;
    tick();
    vectors++;
    if (fifo_wr_trigger !== 1'b1) begin miscompares++; $display("FAIL clken_tmo_grant: trigger got %b expected 1", fifo_wr_trigger); end
    en_cnt = 0;
    n = 0;
    while (n < 400) begin
      clk_en = 1'($urandom_range(0, 1));
      en_prev = clk_en;
      tick();
      n++;
      if (en_prev) en_cnt++;
      if (err_timeout === 1'b1) break;
    end
    vectors++;
    if (err_timeout !== 1'b1 || en_cnt != TMO - 1) begin
      miscompares++;
      $display("FAIL clken_tmo_count: err %b after %0d enabled cycles expected 1 after %0d", err_timeout, en_cnt, TMO - 1);
    end
    clk_en = 1'b0;
    tick();
    vectors++;
    if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL clken_err_hold: got %b expected 1", err_timeout); end
    clk_en = 1'b1;
    tick();
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL clken_err_one_enabled: got %b expected 0", err_timeout); end
    req_valid = '0;
    hang = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] v_edge;
    logic [COLS-1:0]  exp_word;
    logic             trig_prev;
    int               exp_g;
    int               acks;
    apply_reset();
    exp_g = -1;
    exp_word = '0;
    trig_prev = 1'b0;
    acks = 0;
    for (int c = 0; c < 600; c++) begin
      v_edge = req_valid;
      tick();
      if (fifo_wr_trigger === 1'b1 && trig_prev !== 1'b1) begin
        exp_g = ref_pick(v_edge, ref_last);
        exp_word = (exp_g >= 0) ? word[exp_g] : 'x;
        vectors++;
        if (fifo_wr_data !== exp_word) begin
          miscompares++;
          $display("FAIL rand_grant_data[%0d]: got %h expected %h (req %0d)", c, fifo_wr_data, exp_word, exp_g);
        end
        if (exp_g >= 0) word[exp_g] = COLS'($urandom);
      end
      trig_prev = fifo_wr_trigger;
      if (req_ack !== '0) begin
        acks++;
        vectors++;
        if (req_ack !== onehot(exp_g) || err_timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_ack[%0d]: got %b err %b expected %b err 0", c, req_ack, err_timeout, onehot(exp_g));
        end
        check_pop("rand_fifo", exp_word);
        if (exp_g >= 0) begin
          ref_last = exp_g;
          req_valid[exp_g] = 1'b0;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          word[i] = COLS'($urandom);
        end
      end
      wr_lat = $urandom_range(1, 3);
    end
    vectors++;
    if (acks < 20) begin miscompares++; $display("FAIL rand_progress: got %0d acks expected at least 20", acks); end
    req_valid = '0;
    repeat (10) tick();
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) word[i] = '0;
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_timeout();
    test_reset_mid();
    test_clk_en();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of `FifoBuffer` among `N_REQ` producers, such as the UART command receiver and the G-code re-injection path. It owns the FIFO `wr_trigger` / `wr_rdy` / `wr_done` handshake and grants one producer at a time. It holds off while the FIFO is full and recovers from a hung write with a timeout. It sits between the producers and the FIFO; the FIFO read port is not touched.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `COLS`, `BYTE_BITS`, data width; equals the FIFO `COLS`
- `TIMEOUT_CYCLES`, 64, enabled cycles allowed per write before abort (≥4)
- `clk` in 1: the single clock; everything is on its rising edge
- `reset` in 1: asynchronous, active-high
- `clk_en` in 1: when low, all registers hold
- `req_valid` in `N_REQ`: requester i has a word
- `req_data` in `N_REQ`×`COLS`: packed; slice i belongs to requester i
- `req_ack` out `N_REQ`: one-hot pulse; requester i's word was written
- `fifo_wr_trigger` out 1: to FIFO `wr_trigger`
- `fifo_wr_data` out `COLS`: to FIFO `wr_data`
- `fifo_wr_rdy` in 1: from FIFO
- `fifo_wr_done` in 1: from FIFO
- `fifo_is_full` in 1: from FIFO
- `err_timeout` out 1: pulse; the current write was aborted
- `busy` out 1: state is not IDLE

## Operation
- Reset values:
  - state IDLE
  - `req_ack`=0, `fifo_wr_trigger`=0, `fifo_wr_data`=0
  - `err_timeout`=0, `busy`=0
  - `last_grant`=`N_REQ`-1, so requester 0 wins first
- States:
  - IDLE → ISSUE when `|req_valid` && `!fifo_is_full` && `fifo_wr_rdy`.
    - Winner is the first valid index after `last_grant`, scanning cyclically.
    - Latch the winner into `grant` and its data into `fifo_wr_data`.
    - Set `fifo_wr_trigger`=1.
  - ISSUE: hold trigger and data until `fifo_wr_rdy`==0, then clear the trigger → WAIT_DONE.
  - WAIT_DONE → IDLE on `fifo_wr_done` or `fifo_wr_rdy` rising.
    - Pulse `req_ack[grant]`.
    - Set `last_grant`=`grant`.
- Timeout:
  - The counter clears on entry to ISSUE and increments in ISSUE and WAIT_DONE.
  - At `TIMEOUT_CYCLES`-1:
    - drop the trigger;
    - pulse `err_timeout`;
    - do not pulse `req_ack`;
    - still set `last_grant`=`grant` (fairness);
    - go to IDLE.
- Requesters:
  - Hold `req_valid` until they see `req_ack`.
  - Data is sampled only at grant; later changes are ignored.
  - Deasserting `req_valid` mid-transaction does not cancel the write.
- Full:
  - Checked only in IDLE.
  - A write already issued completes; the FIFO rejects it by itself.
- Read port:
  - A simultaneous FIFO read (read wins inside the FIFO) only delays `wr_rdy`/`wr_done`.
  - The arbiter keeps waiting, bounded by the timeout.
- Reset mid-transaction: everything returns to reset values immediately; no ack.

## Timing
- Idle valid request → trigger high on the next enabled edge (1 cycle).
- Trigger stays high at least 1 cycle and drops on the edge after `wr_rdy` is seen low.
- `req_ack` and `err_timeout` are registered, last exactly one enabled cycle, and are mutually exclusive.
- Back-to-back throughput: a return to IDLE costs 1 cycle before the next grant.
  - Minimum 4 cycles per word with an immediate FIFO response.
- `clk_en` low freezes all registers, including pulse outputs and the timeout counter.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `grant_count` [`N_REQ`×16]: per-requester saturating count of successful writes.
  - Adds output `timeout_count` [16]: saturating count of timeouts.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- `fifo_arb_pkg`:
  - state enum `fifo_arb_state_t` {IDLE, ISSUE, WAIT_DONE};
  - `FIFO_ARB_CNT_BITS`=16;
  - `N_REQ` limit constants.
- Sub-module `rr_picker`:
  - Combinational.
  - Inputs: `valid` vector and `last_grant`.
  - Outputs: `any` and winner index.
  - Reused later for the motor-command scheduler.

## Test plan
- Single request: requester 2 valid with 0x41, FIFO empty → trigger 1 cycle after valid; `fifo_wr_data`=0x41; `req_ack`=4'b0100 once after `wr_done`.
- Fairness: all four valid continuously with data 1..4 → grant order 0,1,2,3,0; each ack one-hot; FIFO contents 1,2,3,4 in order.
- Full: `fifo_is_full`=1 with requester 0 valid → no trigger and `busy`=0 for 20 cycles; trigger within 1 cycle of full dropping.
- Timeout: FIFO model never returns `wr_rdy` → `err_timeout` pulses at cycle 63 after trigger; no ack; next grant goes to the following requester.
- Reset mid-WAIT_DONE: assert reset while waiting → trigger, ack and busy at 0 immediately; after release, requester 0 has priority.
- `clk_en` gating: toggle `clk_en` 1/0 during a write → ack still exactly one enabled cycle; timeout counts only enabled cycles.
